img_rom_reader: RTL
===================

# img_rom_reader

Read-side initiator for the picture ROM in the HDMI binarization path. On a start pulse it sweeps the ROM address from 0 to IMG_W*IMG_H-1 and absorbs the fixed ROM read latency. It delivers the pixels as a valid/ready stream with frame and line markers, so the downstream binarization and timing logic can stall freely without losing words.

## Interface
- ADDR_WIDTH, 16: ROM address width.
- DATA_WIDTH, 24: pixel width (RGB888).
- IMG_W, 256: pixels per line, ≥2.
- IMG_H, 256: lines per frame, ≥1; IMG_W*IMG_H ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; ROM shares it.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle frame request; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pixel handshake.
- rom_addr  out  ADDR_WIDTH  registered address to ROM.
- rom_data  in  DATA_WIDTH  ROM read data.
- m_valid  out  1  pixel valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  pixel.
- m_sof  out  1  first pixel of frame (address 0).
- m_eol  out  1  last pixel of each line.
- m_eof  out  1  last pixel of frame.

## Operation
- FSM states:
  - IDLE: start → RUN.
  - RUN: issues addresses; after the issue of address IMG_W*IMG_H-1 → DRAIN.
  - DRAIN: waits for the FIFO and in-flight words to empty and the final handshake; then pulses done → IDLE.
- Issue rule in RUN: one address per cycle when fifo_count + inflight < FIFO_DEPTH (4). Uses registered counts; a same-cycle pop does not grant credit.
- rom_addr advances only on issue. It holds its last value otherwise and returns to 0 on entering IDLE.
- In-flight tracker: a shift register of length ROM_LAT carrying issue-valid plus the sof/eol/eof tags computed at issue time.
  - sof when addr = 0.
  - eol when column counter = IMG_W-1.
  - eof when addr = IMG_W*IMG_H-1.
- Column counter wraps IMG_W-1 → 0; no division.
- The word is written to a 4-entry show-ahead FIFO when the tracker's output stage is valid. The FIFO cannot overflow because of the credit rule.
- m_data, m_sof, m_eol and m_eof come straight from the FIFO head and are stable while m_valid && !m_ready.
- Handshake: a transfer occurs when m_valid && m_ready. m_valid never drops without a transfer.
- start during busy is dropped, with no queuing.
- rst mid-frame: FSM → IDLE, counters, FIFO and tracker cleared. ROM data still in flight is discarded.

## Timing
- Reset values:
  - busy, done, m_valid, m_sof, m_eol, m_eof = 0.
  - rom_addr = 0; m_data = 0.
- ROM_LAT = 1 (2 with ROM_OUTREG_EN): an address presented in cycle n appears on rom_data in cycle n+ROM_LAT.
- Start sampled in cycle 0:
  - busy = 1 and address 0 presented in cycle 1.
  - First m_valid in cycle 2+ROM_LAT.
- Throughput: with m_ready held high, one pixel per cycle after the first. A full frame takes IMG_W*IMG_H + ROM_LAT + 2 cycles from start to done.
- done and busy: done pulses in the cycle after the eof handshake. busy falls in that same cycle. A start in the done cycle is accepted.

## Configuration
- ROM_OUTREG_EN:
  - Defined: ROM_LAT = 2, matching a ROM built with its output register enabled.
  - Undefined: ROM_LAT = 1.
- FIFO_DEPTH stays 4 in both cases, which keeps full throughput.

## Structure
- Package img_rom_pkg:
  - state enum {IDLE, RUN, DRAIN}.
  - FIFO_DEPTH = 4.
  - ROM_LAT, derived from ROM_OUTREG_EN.
  - Packed pixel-with-tags struct (data, sof, eol, eof).
- Sub-module img_rom_fifo: 4-entry show-ahead FIFO of the tagged struct with count output, asynchronous reset.
- Top module holds the FSM, address and column counters, credit logic and latency tracker.

## Test plan
All scenarios use IMG_W=4, IMG_H=2 and a ROM model where word k = 24'h00_00_k.
- Reset then start, m_ready=1 → pixels 0..7 on consecutive cycles, first m_valid in cycle 3 (4 with macro). sof on 0, eol on 3 and 7, eof on 7, done in the cycle after pixel 7.
- m_ready low from pixel 2 for 10 cycles → m_data holds 2 stable, rom_addr stops advancing with ≤4 words outstanding, no loss or duplicate, order 0..7.
- Random 50% m_ready → output sequence exactly 0..7 with correct tags, fifo_count+inflight never exceeds 4.
- start pulsed during busy → ignored, a single frame is delivered, one done pulse.
- rst asserted at pixel 5 then a new start → stale words are never output, new frame begins at 0 with sof.
- Back-to-back: start in the done cycle → second frame starts correctly with busy continuously high except for the done cycle.

Source files
------------

// File: rtl/img_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module   : img_rom_pkg
// Purpose  : Shared types and constants for the picture-ROM read initiator.
//            ROM_OUTREG_EN selects the two-cycle ROM read latency.
// Revision : 1.0 - initial release
// ============================================================================
package img_rom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 4;

`ifdef ROM_OUTREG_EN
    localparam int ROM_LAT = 2;
`else
    localparam int ROM_LAT = 1;
`endif

    localparam int PIX_WIDTH = 24;

    typedef struct packed {
        logic [PIX_WIDTH-1:0] data;
        logic                 sof;
        logic                 eol;
        logic                 eof;
    } pix_t;

endpackage
`default_nettype wire

// File: rtl/img_rom_fifo.sv
`default_nettype none
// ============================================================================
// Module   : img_rom_fifo
// Purpose  : Four-entry show-ahead FIFO of tagged pixels with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module img_rom_fifo
    import img_rom_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  pix_t                          i_data,
    input  logic                          i_pop,
    output pix_t                          o_head,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    pix_t               r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_pop;

    // Popping an empty FIFO is a no-op so the pointers never run ahead.
    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (!i_push && w_pop) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/img_rom_reader.sv
`default_nettype none
// ============================================================================
// Module   : img_rom_reader
// Purpose  : Sweeps the picture ROM and streams tagged pixels with back-pressure.
//            ROM_OUTREG_EN (define) matches a ROM with its output register on.
// Revision : 1.0 - initial release
// ============================================================================
module img_rom_reader
    import img_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 24,
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof
);

    localparam int                    c_COL_W     = $clog2(IMG_W);
    localparam int                    c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [c_COL_W-1:0]    c_LAST_COL  = c_COL_W'(IMG_W - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_COL_W-1:0]    r_col;
    logic                  r_done;
    logic [ROM_LAT-1:0]    r_trk_vld;
    logic [2:0]            r_trk_tag [ROM_LAT];
    logic [c_CNT_W-1:0]    w_fifo_cnt;
    logic [c_CNT_W-1:0]    w_inflight;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_pop;
    logic                  w_eof_hs;
    logic                  w_to_idle;
    pix_t                  w_push_pix;
    pix_t                  w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            w_inflight = w_inflight + c_CNT_W'(r_trk_vld[i]);
        end
    end

    // Credit uses registered occupancy only; a pop this cycle frees space next cycle.
    assign w_issue      = (r_state == RUN) &&
                          ((w_fifo_cnt + w_inflight) < c_CNT_W'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_addr == c_LAST_ADDR);
    assign w_pop        = m_valid && m_ready;
    assign w_eof_hs     = w_pop && w_head.eof;
    assign w_to_idle    = (r_state != IDLE) && (w_state_nxt == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)        w_state_nxt = RUN;
            RUN:     if (w_last_issue) w_state_nxt = DRAIN;
            DRAIN:   if (w_eof_hs)     w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // The last address is held until the frame completes, then rewinds to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_col  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == DRAIN) && w_eof_hs;
            if (w_to_idle) begin
                r_addr <= '0;
                r_col  <= '0;
            end else if (w_issue) begin
                if (!w_last_issue) begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
                r_col <= (r_col == c_LAST_COL) ? '0 : r_col + c_COL_W'(1);
            end
        end
    end

    // Tracker stage k mirrors the ROM pipeline; tags are {sof, eol, eof}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trk_vld <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_trk_tag[i] <= '0;
            end
        end else begin
            r_trk_vld[0] <= w_issue;
            r_trk_tag[0] <= {r_addr == '0, r_col == c_LAST_COL, r_addr == c_LAST_ADDR};
            for (int i = 1; i < ROM_LAT; i++) begin
                r_trk_vld[i] <= r_trk_vld[i-1];
                r_trk_tag[i] <= r_trk_tag[i-1];
            end
        end
    end

    always_comb begin
        w_push_pix      = '0;
        w_push_pix.data = PIX_WIDTH'(rom_data);
        w_push_pix.sof  = r_trk_tag[ROM_LAT-1][2];
        w_push_pix.eol  = r_trk_tag[ROM_LAT-1][1];
        w_push_pix.eof  = r_trk_tag[ROM_LAT-1][0];
    end

    img_rom_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_trk_vld[ROM_LAT-1]),
        .i_data  (w_push_pix),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_cnt)
    );

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign rom_addr = r_addr;
    assign m_valid  = (w_fifo_cnt != '0);
    assign m_data   = DATA_WIDTH'(w_head.data);
    assign m_sof    = w_head.sof;
    assign m_eol    = w_head.eol;
    assign m_eof    = w_head.eof;

endmodule
`default_nettype wire
